// File: rtl/hazard_gen_pkg.sv
// Shared hazard encoding and hazard-unit FSM state type.
// Code values are fixed because the pipeline decodes them directly.
package enum_helpers;

  typedef enum logic [3:0] {
    A_STALL      = 4'h0,
    B_STALL      = 4'h1,
    STALL_FROM_A = 4'h2,
    STALL_FROM_B = 4'h3,
    EX_MEM_A     = 4'h4,
    EX_MEM_B     = 4'h5,
    MEM_WB_A     = 4'h6,
    MEM_WB_B     = 4'h7,
    FORW_FROM_A  = 4'h8,
    HOLD_B       = 4'h9,
    B_INVALID    = 4'hA,
    NONE_h       = 4'hB
  } hazard_signal_t;

  // State names carry a prefix because HOLD_B is already a hazard code.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_HOLD_B     = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_gen_if.sv
// Hazard unit bundle: ID/EX/MEM operand and producer info in, forwarding and stall controls out.
interface hazard_gen_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_a_rs1, id_a_rs2, id_b_rs1, id_b_rs2, id_a_rd;
  logic             id_a_valid, id_b_valid, id_a_memread;
  logic [REG_W-1:0] ex_a_rd, ex_b_rd;
  logic             ex_a_regwrite, ex_b_regwrite, ex_a_memread, ex_b_memread;
  logic [REG_W-1:0] mem_a_rd, mem_b_rd;
  logic             mem_a_regwrite, mem_b_regwrite;
  logic [3:0]       fwd_a1, fwd_a2, fwd_b1, fwd_b2;
  logic [3:0]       stall_code;
  logic             stall;
  logic             b_issue;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_a_rs1, id_a_rs2, id_b_rs1, id_b_rs2, id_a_rd,
    output id_a_valid, id_b_valid, id_a_memread,
    output ex_a_rd, ex_b_rd, ex_a_regwrite, ex_b_regwrite, ex_a_memread, ex_b_memread,
    output mem_a_rd, mem_b_rd, mem_a_regwrite, mem_b_regwrite,
    input  fwd_a1, fwd_a2, fwd_b1, fwd_b2, stall_code, stall, b_issue, stall_cnt
  );

  modport slave (
    input  id_a_rs1, id_a_rs2, id_b_rs1, id_b_rs2, id_a_rd,
    input  id_a_valid, id_b_valid, id_a_memread,
    input  ex_a_rd, ex_b_rd, ex_a_regwrite, ex_b_regwrite, ex_a_memread, ex_b_memread,
    input  mem_a_rd, mem_b_rd, mem_a_regwrite, mem_b_regwrite,
    output fwd_a1, fwd_a2, fwd_b1, fwd_b2, stall_code, stall, b_issue, stall_cnt
  );
endinterface

// File: rtl/hazard_gen_fwd_select.sv
// Per-operand forwarding source priority: slot-A ALU result, EX (B then A), MEM (B then A).
module fwd_select
  import enum_helpers::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic             valid,
  input  logic             a_fwd_en,
  input  logic [REG_W-1:0] id_a_rd,
  input  logic [REG_W-1:0] ex_a_rd,
  input  logic             ex_a_regwrite,
  input  logic [REG_W-1:0] ex_b_rd,
  input  logic             ex_b_regwrite,
  input  logic [REG_W-1:0] mem_a_rd,
  input  logic             mem_a_regwrite,
  input  logic [REG_W-1:0] mem_b_rd,
  input  logic             mem_b_regwrite,
  output hazard_signal_t   code
);

  function automatic logic hit(input logic [REG_W-1:0] rd, input logic we,
                               input logic [REG_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  always_comb begin
    code = NONE_h;
    if (valid) begin
      if (hit(id_a_rd, a_fwd_en, rs))                code = FORW_FROM_A;
      else if (hit(ex_b_rd, ex_b_regwrite, rs))      code = EX_MEM_B;
      else if (hit(ex_a_rd, ex_a_regwrite, rs))      code = EX_MEM_A;
      else if (hit(mem_b_rd, mem_b_regwrite, rs))    code = MEM_WB_B;
      else if (hit(mem_a_rd, mem_a_regwrite, rs))    code = MEM_WB_A;
    end
  end

endmodule

// File: rtl/hazard_gen.sv
// Dual-issue hazard unit: registered forwarding codes, load-use stall and slot-B hold sequencing.
module hazard_gen
  import enum_helpers::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_gen_if.slave bus
);

  // state         | meaning
  // ST_RUN        | evaluate ID bundle each cycle, issue or raise a stall/hold
  // ST_LOAD_STALL | one bubble cycle after a load-use stall
  // ST_HOLD_B     | slot A already issued; slot B issues alone this cycle

  hazard_state_t    state_q, state_d;
  hazard_signal_t   f_a1, f_a2, f_b1, f_b2;
  hazard_signal_t   fwd_a1_q, fwd_a2_q, fwd_b1_q, fwd_b2_q;
  hazard_signal_t   fwd_a1_d, fwd_a2_d, fwd_b1_d, fwd_b2_d;
  hazard_signal_t   stall_code;
  logic             stall, b_issue_q, b_issue_d;
  logic [CNT_W-1:0] cnt_q;
  logic             a_fwd_en, ex_a_ld, ex_b_ld, ld_a, ld_b, hold;

  assign a_fwd_en = bus.id_a_valid && !bus.id_a_memread && (state_q == ST_RUN);
  assign ex_a_ld  = bus.ex_a_regwrite && bus.ex_a_memread && (bus.ex_a_rd != '0);
  assign ex_b_ld  = bus.ex_b_regwrite && bus.ex_b_memread && (bus.ex_b_rd != '0);

  assign ld_a = bus.id_a_valid &&
                ((ex_a_ld && (bus.ex_a_rd == bus.id_a_rs1 || bus.ex_a_rd == bus.id_a_rs2)) ||
                 (ex_b_ld && (bus.ex_b_rd == bus.id_a_rs1 || bus.ex_b_rd == bus.id_a_rs2)));
  assign ld_b = bus.id_b_valid &&
                ((ex_a_ld && (bus.ex_a_rd == bus.id_b_rs1 || bus.ex_a_rd == bus.id_b_rs2)) ||
                 (ex_b_ld && (bus.ex_b_rd == bus.id_b_rs1 || bus.ex_b_rd == bus.id_b_rs2)));
  assign hold = bus.id_a_valid && bus.id_b_valid && bus.id_a_memread && (bus.id_a_rd != '0) &&
                (bus.id_a_rd == bus.id_b_rs1 || bus.id_a_rd == bus.id_b_rs2);

  fwd_select #(.REG_W(REG_W)) u_fwd_a1 (
    .rs(bus.id_a_rs1), .valid(bus.id_a_valid), .a_fwd_en(1'b0), .id_a_rd(bus.id_a_rd),
    .ex_a_rd(bus.ex_a_rd), .ex_a_regwrite(bus.ex_a_regwrite),
    .ex_b_rd(bus.ex_b_rd), .ex_b_regwrite(bus.ex_b_regwrite),
    .mem_a_rd(bus.mem_a_rd), .mem_a_regwrite(bus.mem_a_regwrite),
    .mem_b_rd(bus.mem_b_rd), .mem_b_regwrite(bus.mem_b_regwrite), .code(f_a1));
  fwd_select #(.REG_W(REG_W)) u_fwd_a2 (
    .rs(bus.id_a_rs2), .valid(bus.id_a_valid), .a_fwd_en(1'b0), .id_a_rd(bus.id_a_rd),
    .ex_a_rd(bus.ex_a_rd), .ex_a_regwrite(bus.ex_a_regwrite),
    .ex_b_rd(bus.ex_b_rd), .ex_b_regwrite(bus.ex_b_regwrite),
    .mem_a_rd(bus.mem_a_rd), .mem_a_regwrite(bus.mem_a_regwrite),
    .mem_b_rd(bus.mem_b_rd), .mem_b_regwrite(bus.mem_b_regwrite), .code(f_a2));
  fwd_select #(.REG_W(REG_W)) u_fwd_b1 (
    .rs(bus.id_b_rs1), .valid(bus.id_b_valid), .a_fwd_en(a_fwd_en), .id_a_rd(bus.id_a_rd),
    .ex_a_rd(bus.ex_a_rd), .ex_a_regwrite(bus.ex_a_regwrite),
    .ex_b_rd(bus.ex_b_rd), .ex_b_regwrite(bus.ex_b_regwrite),
    .mem_a_rd(bus.mem_a_rd), .mem_a_regwrite(bus.mem_a_regwrite),
    .mem_b_rd(bus.mem_b_rd), .mem_b_regwrite(bus.mem_b_regwrite), .code(f_b1));
  fwd_select #(.REG_W(REG_W)) u_fwd_b2 (
    .rs(bus.id_b_rs2), .valid(bus.id_b_valid), .a_fwd_en(a_fwd_en), .id_a_rd(bus.id_a_rd),
    .ex_a_rd(bus.ex_a_rd), .ex_a_regwrite(bus.ex_a_regwrite),
    .ex_b_rd(bus.ex_b_rd), .ex_b_regwrite(bus.ex_b_regwrite),
    .mem_a_rd(bus.mem_a_rd), .mem_a_regwrite(bus.mem_a_regwrite),
    .mem_b_rd(bus.mem_b_rd), .mem_b_regwrite(bus.mem_b_regwrite), .code(f_b2));

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    stall_code = NONE_h;
    fwd_a1_d   = f_a1;
    fwd_a2_d   = f_a2;
    fwd_b1_d   = bus.id_b_valid ? f_b1 : B_INVALID;
    fwd_b2_d   = bus.id_b_valid ? f_b2 : B_INVALID;
    b_issue_d  = bus.id_b_valid;
    case (state_q)
      ST_RUN: begin
        if (ld_a || ld_b) begin
          // Load-use wins over the slot-B hold; the whole bundle waits.
          stall      = 1'b1;
          stall_code = ld_a ? A_STALL : B_STALL;
          fwd_a1_d   = NONE_h;
          fwd_a2_d   = NONE_h;
          fwd_b1_d   = NONE_h;
          fwd_b2_d   = NONE_h;
          b_issue_d  = 1'b0;
          state_d    = ST_LOAD_STALL;
        end else if (hold) begin
          stall      = 1'b1;
          stall_code = HOLD_B;
          fwd_b1_d   = B_INVALID;
          fwd_b2_d   = B_INVALID;
          b_issue_d  = 1'b0;
          state_d    = ST_HOLD_B;
        end
      end
      ST_LOAD_STALL: begin
        fwd_a1_d  = NONE_h;
        fwd_a2_d  = NONE_h;
        fwd_b1_d  = NONE_h;
        fwd_b2_d  = NONE_h;
        b_issue_d = 1'b0;
        state_d   = ST_RUN;
      end
      ST_HOLD_B: begin
        fwd_a1_d = NONE_h;
        fwd_a2_d = NONE_h;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      stall      = 1'b0;
      stall_code = NONE_h;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      fwd_a1_q  <= NONE_h;
      fwd_a2_q  <= NONE_h;
      fwd_b1_q  <= NONE_h;
      fwd_b2_q  <= NONE_h;
      b_issue_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fwd_a1_q  <= fwd_a1_d;
      fwd_a2_q  <= fwd_a2_d;
      fwd_b1_q  <= fwd_b1_d;
      fwd_b2_q  <= fwd_b2_d;
      b_issue_q <= b_issue_d;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.fwd_a1     = fwd_a1_q;
  assign bus.fwd_a2     = fwd_a2_q;
  assign bus.fwd_b1     = fwd_b1_q;
  assign bus.fwd_b2     = fwd_b2_q;
  assign bus.stall      = stall;
  assign bus.stall_code = stall_code;
  assign bus.b_issue    = b_issue_q;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_gen.sv
// Directed-vector bench for hazard_gen; counter narrowed to 4 bits so saturation is reachable.
module tb_hazard_gen;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_gen_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

  hazard_gen #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    hif.id_a_rs1 = '0; hif.id_a_rs2 = '0; hif.id_b_rs1 = '0; hif.id_b_rs2 = '0;
    hif.id_a_rd = '0; hif.id_a_valid = 1'b0; hif.id_b_valid = 1'b0; hif.id_a_memread = 1'b0;
    hif.ex_a_rd = '0; hif.ex_b_rd = '0; hif.ex_a_regwrite = 1'b0; hif.ex_b_regwrite = 1'b0;
    hif.ex_a_memread = 1'b0; hif.ex_b_memread = 1'b0;
    hif.mem_a_rd = '0; hif.mem_b_rd = '0; hif.mem_a_regwrite = 1'b0; hif.mem_b_regwrite = 1'b0;
  endtask

  task automatic set_load_use_a(input logic [4:0] r);
    clear();
    hif.ex_a_rd = r; hif.ex_a_regwrite = 1'b1; hif.ex_a_memread = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_a_rs2 = r;
  endtask

  task automatic check_all_fwd(input string tag, input logic [3:0] exp);
    check({tag, "_a1"}, 16'(hif.fwd_a1), 16'(exp));
    check({tag, "_a2"}, 16'(hif.fwd_a2), 16'(exp));
    check({tag, "_b1"}, 16'(hif.fwd_b1), 16'(exp));
    check({tag, "_b2"}, 16'(hif.fwd_b2), 16'(exp));
  endtask

  initial begin
    clear();
    reset = 1'b1;
    set_load_use_a(5'd3);
    step();
    step();
    check("rst_stall", 16'(hif.stall), 16'h0);
    check("rst_code", 16'(hif.stall_code), 16'hB);
    check_all_fwd("rst_fwd", 4'hB);
    check("rst_bissue", 16'(hif.b_issue), 16'h0);
    check("rst_cnt", 16'(hif.stall_cnt), 16'h0);

    reset = 1'b0;
    clear();
    step();

    // EX_MEM_A with latency of one cycle
    hif.ex_a_rd = 5'd5; hif.ex_a_regwrite = 1'b1; hif.id_a_valid = 1'b1; hif.id_a_rs1 = 5'd5;
    #1;
    check("exa_nostall", 16'(hif.stall), 16'h0);
    check("exa_code", 16'(hif.stall_code), 16'hB);
    check("exa_latency", 16'(hif.fwd_a1), 16'hB);
    step();
    check("exa_a1", 16'(hif.fwd_a1), 16'h4);
    check("exa_a2", 16'(hif.fwd_a2), 16'hB);
    check("exa_b1_invalid", 16'(hif.fwd_b1), 16'hA);
    check("exa_bissue", 16'(hif.b_issue), 16'h0);

    // EX slot B beats slot A
    clear();
    hif.ex_a_rd = 5'd7; hif.ex_b_rd = 5'd7; hif.ex_a_regwrite = 1'b1; hif.ex_b_regwrite = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_b_valid = 1'b1; hif.id_b_rs2 = 5'd7;
    step();
    check("exb_b2", 16'(hif.fwd_b2), 16'h5);
    check("exb_b1", 16'(hif.fwd_b1), 16'hB);
    check("exb_bissue", 16'(hif.b_issue), 16'h1);

    // MEM slot B beats slot A; MEM slot A alone
    clear();
    hif.mem_a_rd = 5'd6; hif.mem_b_rd = 5'd6; hif.mem_a_regwrite = 1'b1; hif.mem_b_regwrite = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_a_rs1 = 5'd6;
    step();
    check("memb_a1", 16'(hif.fwd_a1), 16'h7);
    clear();
    hif.mem_a_rd = 5'd8; hif.mem_a_regwrite = 1'b1; hif.id_a_valid = 1'b1; hif.id_a_rs2 = 5'd8;
    step();
    check("mema_a2", 16'(hif.fwd_a2), 16'h6);

    // Slot-A ALU result beats EX for slot B
    clear();
    hif.id_a_valid = 1'b1; hif.id_a_rd = 5'd4; hif.id_b_valid = 1'b1; hif.id_b_rs1 = 5'd4;
    hif.ex_b_rd = 5'd4; hif.ex_b_regwrite = 1'b1;
    step();
    check("forwa_b1", 16'(hif.fwd_b1), 16'h8);

    // Load-use from slot A
    set_load_use_a(5'd3);
    #1;
    check("lu_a_stall", 16'(hif.stall), 16'h1);
    check("lu_a_code", 16'(hif.stall_code), 16'h0);
    step();
    check_all_fwd("lu_a_bubble", 4'hB);
    check("lu_a_bissue", 16'(hif.b_issue), 16'h0);
    check("lu_a_cnt", 16'(hif.stall_cnt), 16'h1);
    check("lu_a_stall_cleared", 16'(hif.stall), 16'h0);
    clear();
    step();
    check("lu_a_bubble2_b1", 16'(hif.fwd_b1), 16'hB);

    // Load-use from slot B only, then both slots
    clear();
    hif.ex_b_rd = 5'd10; hif.ex_b_regwrite = 1'b1; hif.ex_b_memread = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_b_valid = 1'b1; hif.id_b_rs1 = 5'd10;
    #1;
    check("lu_b_code", 16'(hif.stall_code), 16'h1);
    step();
    check("lu_b_cnt", 16'(hif.stall_cnt), 16'h2);
    clear();
    step();
    hif.ex_b_rd = 5'd10; hif.ex_b_regwrite = 1'b1; hif.ex_b_memread = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_b_valid = 1'b1; hif.id_b_rs1 = 5'd10; hif.id_a_rs1 = 5'd10;
    #1;
    check("lu_both_code", 16'(hif.stall_code), 16'h0);
    step();
    check("lu_both_cnt", 16'(hif.stall_cnt), 16'h3);
    clear();
    step();

    // Slot-B hold behind a slot-A load
    hif.id_a_valid = 1'b1; hif.id_a_memread = 1'b1; hif.id_a_rd = 5'd9;
    hif.id_b_valid = 1'b1; hif.id_b_rs1 = 5'd9;
    hif.id_a_rs1 = 5'd2; hif.mem_a_rd = 5'd2; hif.mem_a_regwrite = 1'b1;
    #1;
    check("hold_stall", 16'(hif.stall), 16'h1);
    check("hold_code", 16'(hif.stall_code), 16'h9);
    step();
    check("hold_b1", 16'(hif.fwd_b1), 16'hA);
    check("hold_b2", 16'(hif.fwd_b2), 16'hA);
    check("hold_bissue0", 16'(hif.b_issue), 16'h0);
    check("hold_a1", 16'(hif.fwd_a1), 16'h6);
    check("hold_cnt", 16'(hif.stall_cnt), 16'h4);
    check("hold_state_nostall", 16'(hif.stall), 16'h0);
    hif.ex_a_rd = 5'd9; hif.ex_a_regwrite = 1'b1; hif.ex_a_memread = 1'b1;
    step();
    check("hold_issue", 16'(hif.b_issue), 16'h1);
    check("hold_a1_supp", 16'(hif.fwd_a1), 16'hB);
    check("hold_a2_supp", 16'(hif.fwd_a2), 16'hB);
    check("hold_b1_load", 16'(hif.fwd_b1), 16'h4);
    clear();
    step();

    // Load-use and hold in the same cycle
    hif.ex_a_rd = 5'd3; hif.ex_a_regwrite = 1'b1; hif.ex_a_memread = 1'b1;
    hif.id_a_valid = 1'b1; hif.id_a_memread = 1'b1; hif.id_a_rd = 5'd9;
    hif.id_b_valid = 1'b1; hif.id_b_rs1 = 5'd9; hif.id_b_rs2 = 5'd3;
    #1;
    check("prio_code", 16'(hif.stall_code), 16'h1);
    step();
    check("prio_b1", 16'(hif.fwd_b1), 16'hB);
    check("prio_cnt", 16'(hif.stall_cnt), 16'h5);
    clear();
    step();

    // Register zero never matches
    hif.id_a_valid = 1'b1; hif.id_b_valid = 1'b1; hif.id_a_memread = 1'b1;
    hif.ex_a_regwrite = 1'b1; hif.ex_b_regwrite = 1'b1; hif.ex_a_memread = 1'b1; hif.ex_b_memread = 1'b1;
    hif.mem_a_regwrite = 1'b1; hif.mem_b_regwrite = 1'b1;
    #1;
    check("r0_stall", 16'(hif.stall), 16'h0);
    check("r0_code", 16'(hif.stall_code), 16'hB);
    step();
    check_all_fwd("r0_fwd", 4'hB);
    check("r0_bissue", 16'(hif.b_issue), 16'h1);
    clear();
    step();

    // Drive the counter to saturation
    for (int i = 0; i < 10; i++) begin
      set_load_use_a(5'd3);
      step();
      clear();
      step();
    end
    check("sat_reach", 16'(hif.stall_cnt), 16'hF);
    set_load_use_a(5'd3);
    step();
    check("sat_hold", 16'(hif.stall_cnt), 16'hF);
    clear();
    step();

    // Reset while in LOAD_STALL
    set_load_use_a(5'd3);
    step();
    reset = 1'b1;
    step();
    check_all_fwd("rstls_fwd", 4'hB);
    check("rstls_cnt", 16'(hif.stall_cnt), 16'h0);
    check("rstls_stall", 16'(hif.stall), 16'h0);
    reset = 1'b0;
    #1;
    check("rstls_run_stall", 16'(hif.stall), 16'h1);
    clear();
    hif.ex_a_rd = 5'd5; hif.ex_a_regwrite = 1'b1; hif.id_a_valid = 1'b1; hif.id_a_rs1 = 5'd5;
    step();
    check("rstls_no_bubble", 16'(hif.fwd_a1), 16'h4);
    check("rstls_cnt_after", 16'(hif.stall_cnt), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
